// File: rtl/contador_event_fifo_if.sv
// Event stream from contador_event_fifo to its consumer.
// Latency: none (plain wires); the producer drives valid/data, the consumer drives ready.
// Backpressure: the consumer holds ev_ready low to stall; the producer keeps ev_data stable meanwhile.
//
// Signals:
//   ev_valid  head entry available (producer -> consumer)
//   ev_ready  consumer accepts head entry (consumer -> producer)
//   ev_data   {ev_type[1:0], mode[1:0], Q[3:0], ts[TS_W-1:0]}
interface contador_event_fifo_if #(
  parameter int TS_W = 8
);
  logic                ev_valid;
  logic                ev_ready;
  logic [8+TS_W-1:0]   ev_data;

  // master: event producer (the monitor); slave: event consumer
  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/contador_event_fifo.sv
// Monitors contadorC rco/load, tags each event with type/mode/Q/timestamp and queues it in a FIFO.
// Latency: an event sampled on edge N is visible on ev_valid/ev_data right after edge N (no empty bypass).
// Backpressure: ev_ready low holds the head entry; a push into a full FIFO without a pop is dropped and flagged.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   enable, mode, Q,    counter-side signals as seen by contadorC / produced by it
//   rco, load
//   ev                  contador_event_fifo_if.master: ev_valid / ev_ready / ev_data
//   fifo_count          occupancy 0..DEPTH
//   overflow, ovf_clr   sticky drop flag and its synchronous clear
//   drop_cnt            saturating dropped-event count (only with CONTADOR_EVFIFO_DROP_CNT_EN)
//
// Optional feature: define CONTADOR_EVFIFO_DROP_CNT_EN to add the drop_cnt port and
// its saturating counter (cleared only by reset). Without it only the overflow flag reports loss.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module contador_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int TS_W   = 8
`ifdef CONTADOR_EVFIFO_DROP_CNT_EN
  ,
  parameter int DROP_W = 8
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic [3:0]                  Q,
  input  logic                        rco,
  input  logic                        load,
  contador_event_fifo_if.master       ev,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        overflow,
  input  logic                        ovf_clr
`ifdef CONTADOR_EVFIFO_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]           drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 8 + TS_W;

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [TS_W-1:0] ts;

  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       do_write;
  logic       drop;
  logic [1:0] ev_type;

  // Bit 0 flags rco, bit 1 flags load: 01 rco only, 10 load only, 11 both.
  assign ev_type  = {load, rco};
  assign push     = enable & (rco | load);
  assign full     = (fifo_count == CW'(DEPTH));
  assign empty    = (fifo_count == '0);
  assign pop      = ev.ev_valid & ev.ev_ready;

  // When full, a simultaneous pop frees the slot being written: wr_ptr equals
  // rd_ptr, the head is read out combinationally before the edge and the new
  // entry lands in that same slot as the new tail.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  assign ev.ev_valid = ~empty;
  // Stale storage is never exposed: data reads as zero while empty.
  assign ev.ev_data  = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset; emptiness is tracked by fifo_count alone.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= {ev_type, mode, Q, ts};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ts         <= '0;
      overflow   <= 1'b0;
    end else begin
      // Entries capture ts before this increment.
      ts <= ts + TS_W'(1);

      if (do_write) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({do_write, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef CONTADOR_EVFIFO_DROP_CNT_EN
  // Saturates at all-ones; ovf_clr deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end
`endif

endmodule
